fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline latch and FILL/RUN start-up FSM.
// Optional macro FETCH_STALL_COUNT_EN adds a saturating PC-stall cycle counter.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stop_pc,
  input  logic        stop_latch,
  input  logic        bubble,
  input  logic        branch_mem,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  if_id_opcode,
  output logic [15:0] stall_count
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned SCW  = 16;

  typedef enum logic {ST_FILL = 1'b0, ST_RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_plus4;
  logic              fill_done;

  assign pc_plus4  = pc_q + XLEN'(4);
  assign fill_done = (state_q == ST_RUN);

  // Next-state: any non-reset edge leaves FILL; PC and latch follow their priority chains
  always_comb begin
    state_d = ST_RUN;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;

    if (branch_mem) begin
      pc_d = branch_target;
    end else if (!stop_pc) begin
      pc_d = pc_plus4;
    end

    if (branch_mem || bubble) begin
      instr_d = NOP_WORD;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (!stop_latch) begin
      instr_d = imem_data;
      pc4_d   = pc_plus4;
      valid_d = fill_done;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FILL;
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr    = pc_q;
  assign if_id_instr  = instr_q;
  assign if_id_pc4    = pc4_q;
  assign if_id_valid  = valid_q;
  assign if_id_opcode = instr_q[31:26];

`ifdef FETCH_STALL_COUNT_EN
  logic [SCW-1:0] stall_q, stall_d;

  // Counts held-PC cycles; a redirect is not a stall. Saturates at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (stop_pc && !branch_mem && (stall_q != {SCW{1'b1}})) begin
      stall_d = stall_q + SCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = SCW'(0);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle reference model plus directed literal checks.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'hF000_0013;

  logic        clk = 1'b0;
  logic        rst, stop_pc, stop_latch, bubble, branch_mem;
  logic [31:0] branch_target, imem_data, imem_addr;
  logic [31:0] if_id_instr, if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  if_id_opcode;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .stop_pc(stop_pc), .stop_latch(stop_latch),
    .bubble(bubble), .branch_mem(branch_mem), .branch_target(branch_target),
    .imem_data(imem_data), .imem_addr(imem_addr), .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .if_id_opcode(if_id_opcode),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return ~a;
  endfunction

  assign imem_data = imem_f(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state of the fetch stage as the rules describe it
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_fill, m_known = 1'b0;
  int          m_stall;

  always begin
    @(posedge clk);
    if (rst) begin
      m_pc = RST_PC; m_instr = NOP; m_pc4 = 0; m_valid = 0;
      m_fill = 1; m_stall = 0; m_known = 1;
    end else if (m_known) begin
      logic [31:0] nxt4;
      nxt4 = m_pc + 32'd4;
      if (branch_mem || bubble) begin
        m_instr = NOP; m_pc4 = 0; m_valid = 0;
      end else if (!stop_latch) begin
        m_instr = imem_f(m_pc); m_pc4 = nxt4; m_valid = !m_fill;
      end
`ifdef FETCH_STALL_COUNT_EN
      if (stop_pc && !branch_mem && m_stall < 65535) m_stall++;
`endif
      m_pc   = branch_mem ? branch_target : (stop_pc ? m_pc : nxt4);
      m_fill = 0;
    end
    #1;
    if (m_known) begin
      chk("pc",     imem_addr,                m_pc);
      chk("instr",  if_id_instr,              m_instr);
      chk("pc4",    if_id_pc4,                m_pc4);
      chk("valid",  32'(if_id_valid),         32'(m_valid));
      chk("opcode", 32'(if_id_opcode),        32'(m_instr[31:26]));
      chk("stall",  32'(stall_count),         32'(m_stall));
    end
  end

  // One clock: drive inputs at negedge, return 1 time unit after the following posedge
  task automatic cyc(input logic r, input logic sp, input logic sl, input logic bb,
                     input logic br, input logic [31:0] tgt);
    @(negedge clk);
    rst = r; stop_pc = sp; stop_latch = sl; bubble = bb; branch_mem = br; branch_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 32'h0);
  endtask

  localparam logic [31:0] STALL3 =
`ifdef FETCH_STALL_COUNT_EN
    32'd3;
`else
    32'd0;
`endif

  initial begin
    rst = 1; stop_pc = 0; stop_latch = 0; bubble = 0; branch_mem = 0; branch_target = 0;

    // Reset, with every control input asserted to prove reset overrides them
    cyc(1, 1, 1, 1, 1, 32'h0000_0800);
    cyc(1, 0, 0, 0, 0, 32'h0);
    chk("rst_addr",  imem_addr, 32'h100);
    chk("rst_valid", 32'(if_id_valid), 32'h0);
    chk("rst_instr", if_id_instr, NOP);

    idle();
    chk("fill_valid", 32'(if_id_valid), 32'h0);
    chk("fill_instr", if_id_instr, 32'hFFFF_FEFF);
    chk("fill_pc4",   if_id_pc4, 32'h104);
    idle();
    chk("run_valid", 32'(if_id_valid), 32'h1);
    chk("run_pc4",   if_id_pc4, 32'h108);

    // Free run from 0
    cyc(0, 0, 0, 0, 1, 32'h0);
    chk("fr_addr0", imem_addr, 32'h0);
    idle(); chk("fr_addr4", imem_addr, 32'h4); chk("fr_pc4_4", if_id_pc4, 32'h4);
    idle(); chk("fr_addr8", imem_addr, 32'h8); chk("fr_pc4_8", if_id_pc4, 32'h8);
    idle(); chk("fr_addrC", imem_addr, 32'hC); chk("fr_pc4_C", if_id_pc4, 32'hC);

    // Full stall at PC=8 for 3 cycles
    cyc(0, 0, 0, 0, 1, 32'h4);
    idle();
    repeat (3) cyc(0, 1, 1, 0, 0, 32'h0);
    chk("st_addr",  imem_addr, 32'h8);
    chk("st_instr", if_id_instr, 32'hFFFF_FFFB);
    chk("st_pc4",   if_id_pc4, 32'h8);
    chk("st_valid", 32'(if_id_valid), 32'h1);
    chk("st_count", 32'(stall_count), STALL3);

    // Bubble beats stop_latch
    cyc(0, 1, 1, 1, 0, 32'h0);
    chk("bb_instr", if_id_instr, NOP);
    chk("bb_valid", 32'(if_id_valid), 32'h0);
    chk("bb_addr",  imem_addr, 32'h8);

    // Repeat fetch, then discard fetch
    cyc(0, 1, 0, 0, 0, 32'h0);
    chk("rep_instr", if_id_instr, 32'hFFFF_FFF7);
    chk("rep_addr",  imem_addr, 32'h8);
    cyc(0, 0, 1, 0, 0, 32'h0);
    chk("disc_addr", imem_addr, 32'hC);
    chk("disc_pc4",  if_id_pc4, 32'hC);

    // Branch wins over stop_pc
    cyc(0, 1, 1, 0, 1, 32'h40);
    chk("br_addr",  imem_addr, 32'h40);
    chk("br_valid", 32'(if_id_valid), 32'h0);
    idle();
    chk("br_pc4",   if_id_pc4, 32'h44);
    chk("br_valid2", 32'(if_id_valid), 32'h1);
    chk("br_instr", if_id_instr, 32'hFFFF_FFBF);

    // PC wrap
    cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    idle();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc4",  if_id_pc4, 32'h0);

    // Reset mid-stall and mid-redirect
    cyc(0, 1, 1, 0, 0, 32'h0);
    cyc(1, 1, 0, 0, 1, 32'h0000_0500);
    chk("rr_addr",  imem_addr, 32'h100);
    chk("rr_count", 32'(stall_count), 32'h0);

    // Branch during FILL still redirects, FSM still reaches RUN
    cyc(0, 0, 0, 0, 1, 32'h200);
    chk("fb_addr",  imem_addr, 32'h200);
    chk("fb_valid", 32'(if_id_valid), 32'h0);
    idle();
    chk("fb_valid2", 32'(if_id_valid), 32'h1);
    chk("fb_pc4",    if_id_pc4, 32'h204);

    // Mixed control patterns, checked by the model
    for (int i = 0; i < 60; i++) begin
      cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
          {$urandom_range(0, 255), 2'b00});
    end

`ifdef FETCH_STALL_COUNT_EN
    cyc(1, 0, 0, 0, 0, 32'h0);
    repeat (65540) cyc(0, 1, 1, 0, 0, 32'h0);
    chk("sat_count", 32'(stall_count), 32'h0000_FFFF);
`else
    repeat (5) cyc(0, 1, 1, 0, 0, 32'h0);
    chk("off_count", 32'(stall_count), 32'h0);
`endif

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
